// File: rtl/riscv_alu_if.sv
// ============================================================================
// Module      : riscv_alu_if
// Description : Operand/result bundle between the issue logic and riscv_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [2:0]      func3;
    logic            subsra;
    logic [XLEN-1:0] result;
    logic            out_valid;
    logic            zero;

    modport master (
        output in_valid, operand1, operand2, func3, subsra,
        input  result, out_valid, zero
    );

    modport slave (
        input  in_valid, operand1, operand2, func3, subsra,
        output result, out_valid, zero
    );
endinterface

`default_nettype wire

// File: rtl/riscv_alu.sv
// ============================================================================
// Module      : riscv_alu
// Description : RV32I execute-stage ALU, one-cycle registered result + zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu #(
    parameter int XLEN = 32
) (
    input  wire          clk,
    input  wire          rst,
    riscv_alu_if.slave   bus
);
    localparam logic [2:0] c_F3_ADDSUB = 3'b000;
    localparam logic [2:0] c_F3_SLL    = 3'b001;
    localparam logic [2:0] c_F3_SLT    = 3'b010;
    localparam logic [2:0] c_F3_SLTU   = 3'b011;
    localparam logic [2:0] c_F3_XOR    = 3'b100;
    localparam logic [2:0] c_F3_SRLSRA = 3'b101;
    localparam logic [2:0] c_F3_OR     = 3'b110;
    localparam logic [2:0] c_F3_AND    = 3'b111;

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_result_d;
    logic            w_zero_d;
    logic            w_valid_d;
    logic [XLEN-1:0] r_result_q;
    logic            r_zero_q;
    logic            r_valid_q;

    // Only the low five bits of operand2 ever form a shift amount.
    assign w_shamt = bus.operand2[4:0];

    always_comb begin
        w_alu = '0;
        case (bus.func3)
            c_F3_ADDSUB: w_alu = bus.subsra ? (bus.operand1 - bus.operand2)
                                            : (bus.operand1 + bus.operand2);
            c_F3_SLL:    w_alu = bus.operand1 << w_shamt;
            c_F3_SLT:    w_alu = {{(XLEN-1){1'b0}},
                                  ($signed(bus.operand1) < $signed(bus.operand2))};
            c_F3_SLTU:   w_alu = {{(XLEN-1){1'b0}}, (bus.operand1 < bus.operand2)};
            c_F3_XOR:    w_alu = bus.operand1 ^ bus.operand2;
            c_F3_SRLSRA: w_alu = bus.subsra ? XLEN'($signed(bus.operand1) >>> w_shamt)
                                            : (bus.operand1 >> w_shamt);
            c_F3_OR:     w_alu = bus.operand1 | bus.operand2;
            c_F3_AND:    w_alu = bus.operand1 & bus.operand2;
            default:     w_alu = '0;
        endcase
    end

    // result and zero hold on idle cycles; only out_valid drops.
    always_comb begin
        w_valid_d  = bus.in_valid;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
        if (bus.in_valid) begin
            w_result_d = w_alu;
            w_zero_d   = (w_alu == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b1;
            r_valid_q  <= 1'b0;
        end else begin
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
            r_valid_q  <= w_valid_d;
        end
    end

    assign bus.result    = r_result_q;
    assign bus.zero      = r_zero_q;
    assign bus.out_valid = r_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_riscv_alu.sv
// ============================================================================
// Module      : tb_riscv_alu
// Description : Self-checking bench for riscv_alu (directed + random ops).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_alu;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    riscv_alu_if #(.XLEN(32)) bus ();

    riscv_alu #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        s;
        logic [31:0] e;
    } vec_t;

    // Reference built from arithmetic meaning: shifts as multiply/divide by
    // powers of two, signed values as 64-bit integers.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f, input logic s);
        longint ua, ub, sa, sb, p, r;
        int     sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(ub % 32);
        p  = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        case (f)
            3'd0:    r = s ? (ua - ub) : (ua + ub);
            3'd1:    r = ua * p;
            3'd2:    r = (sa < sb) ? 1 : 0;
            3'd3:    r = (ua < ub) ? 1 : 0;
            3'd4:    r = longint'({32'd0, a ^ b});
            3'd5:    r = !s ? (ua / p)
                            : ((sa >= 0) ? (sa / p) : -(((-sa) + p - 1) / p));
            3'd6:    r = longint'({32'd0, a | b});
            default: r = longint'({32'd0, a & b});
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic s);
        bus.in_valid = v;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.func3    = f;
        bus.subsra   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 32'd32, 32'd30, 3'd0, 1'b0);
        drive(1'b1, 32'd32, 32'd30, 3'd0, 1'b0);
        n_cmp++; if (bus.result !== 32'd0) begin n_err++;
            $display("FAIL reset_result got=%h exp=%h", bus.result, 32'd0); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.zero !== 1'b1) begin n_err++;
            $display("FAIL reset_zero got=%b exp=1", bus.zero); end
    endtask

    task automatic test_handshake;
        rst = 1'b0;
        drive(1'b1, 32'd32, 32'd30, 3'd0, 1'b0);
        n_cmp++; if (bus.result !== 32'd62) begin n_err++;
            $display("FAIL hs_result got=%h exp=%h", bus.result, 32'd62); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++;
            $display("FAIL hs_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++;
            $display("FAIL hs_zero got=%b exp=0", bus.zero); end
        drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL idle_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.result !== 32'd62) begin n_err++;
            $display("FAIL idle_hold got=%h exp=%h", bus.result, 32'd62); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++;
            $display("FAIL idle_zero got=%b exp=0", bus.zero); end
    endtask

    task automatic test_directed;
        vec_t v [0:16];
        v[0]  = '{32'd32,       32'd30,       3'd0, 1'b1, 32'd2};
        v[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 32'hFFFFFFFE};
        v[2]  = '{32'd14,       32'hFFFFFFFA, 3'd0, 1'b1, 32'd20};
        v[3]  = '{32'd745,      32'd745,      3'd4, 1'b0, 32'd0};
        v[4]  = '{32'd32,       32'd30,       3'd4, 1'b0, 32'd62};
        v[5]  = '{32'd5,        32'd3,        3'd1, 1'b1, 32'd40};
        v[6]  = '{32'd24,       32'd2,        3'd5, 1'b0, 32'd6};
        v[7]  = '{32'd24,       32'd2,        3'd5, 1'b1, 32'd6};
        v[8]  = '{32'h80000000, 32'd4,        3'd5, 1'b1, 32'hF8000000};
        v[9]  = '{32'd18,       32'd5,        3'd5, 1'b1, 32'd0};
        v[10] = '{32'd18,       32'hFFFFFFFE, 3'd5, 1'b0, 32'd0};
        v[11] = '{32'd18,       32'hFFFFFFFE, 3'd1, 1'b0, 32'h80000000};
        v[12] = '{32'd32,       32'd30,       3'd2, 1'b0, 32'd0};
        v[13] = '{32'hFFFFFFFF, 32'd1,        3'd2, 1'b0, 32'd1};
        v[14] = '{32'hFFFFFFE0, 32'd30,       3'd3, 1'b0, 32'd0};
        v[15] = '{32'd1,        32'hFFFFFFFF, 3'd3, 1'b0, 32'd1};
        v[16] = '{32'h80000000, 32'd1,        3'd2, 1'b1, 32'd1};
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].f, v[i].s);
            n_cmp++; if (bus.result !== v[i].e) begin n_err++;
                $display("FAIL dir%0d_result f3=%0d sub=%b got=%h exp=%h",
                         i, v[i].f, v[i].s, bus.result, v[i].e); end
            n_cmp++; if (bus.zero !== (v[i].e == 32'd0)) begin n_err++;
                $display("FAIL dir%0d_zero got=%b exp=%b", i, bus.zero, v[i].e == 32'd0); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++;
                $display("FAIL dir%0d_valid got=%b exp=1", i, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        vec_t v [0:2];
        v[0] = '{32'd1,    32'd0,    3'd6, 1'b0, 32'd1};
        v[1] = '{32'd1,    32'd1,    3'd7, 1'b0, 32'd1};
        v[2] = '{32'h0F0,  32'h00F,  3'd7, 1'b0, 32'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].f, v[i].s);
            n_cmp++; if (bus.result !== v[i].e || bus.out_valid !== 1'b1) begin n_err++;
                $display("FAIL b2b%0d got=%h/v%b exp=%h/v1", i, bus.result, bus.out_valid, v[i].e); end
            n_cmp++; if (bus.zero !== (i == 2)) begin n_err++;
                $display("FAIL b2b%0d_zero got=%b exp=%b", i, bus.zero, i == 2); end
        end
    endtask

    task automatic test_mid_reset;
        drive(1'b1, 32'd5, 32'd5, 3'd0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 32'd32, 32'd30, 3'd0, 1'b0);
        n_cmp++; if (bus.result !== 32'd0 || bus.out_valid !== 1'b0 || bus.zero !== 1'b1) begin
            n_err++;
            $display("FAIL midrst got=%h/v%b/z%b exp=0/v0/z1", bus.result, bus.out_valid, bus.zero);
        end
        rst = 1'b0;
        drive(1'b1, 32'd32, 32'd30, 3'd0, 1'b0);
        n_cmp++; if (bus.result !== 32'd62 || bus.out_valid !== 1'b1 || bus.zero !== 1'b0) begin
            n_err++;
            $display("FAIL postrst got=%h/v%b/z%b exp=62/v1/z0", bus.result, bus.out_valid, bus.zero);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, exp_res;
        logic [2:0]  f;
        logic        s, v, exp_zero;
        exp_res  = bus.result === 32'd62 ? 32'd62 : 32'd0;
        exp_res  = 32'd62;
        exp_zero = 1'b0;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = {27'd0, 5'($urandom)};
                2: a = {a[31], 31'd0};
                default: ;
            endcase
            f = 3'($urandom);
            s = 1'($urandom);
            v = ($urandom_range(0, 7) != 0);
            drive(v, a, b, f, s);
            if (v) begin
                exp_res  = ref_alu(a, b, f, s);
                exp_zero = (exp_res == 32'd0);
            end
            n_cmp++; if (bus.result !== exp_res || bus.zero !== exp_zero || bus.out_valid !== v) begin
                n_err++;
                $display("FAIL rand%0d a=%h b=%h f3=%0d sub=%b vin=%b got=%h/z%b/v%b exp=%h/z%b/v%b",
                         i, a, b, f, s, v, bus.result, bus.zero, bus.out_valid,
                         exp_res, exp_zero, v);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        bus.func3    = '0;
        bus.subsra   = 1'b0;
        test_reset();
        test_handshake();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
